valu_issue_seq: RTL

Request-side sequencer for the vector ALU pipeline: accepts one vector command at a time, reads both source operand registers from the vector register file (VRF) one 64-bit chunk per cycle, and drives the ALU's request interface with per-chunk address, byte enables, start index and start/end markers. It sits between instruction dispatch and the ALU and produces exactly the request stream the ALU consumes. The ALU has no backpressure, so the only stall source is the VRF read grant.

---
 rtl/valu_issue_seq.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/valu_issue_seq.sv
// Request-side sequencer for the vector ALU: reads both source operands one 64-bit chunk per
// cycle from the VRF and emits the aligned per-chunk ALU request stream.
module valu_issue_seq #(
  parameter int unsigned REQ_DATA_WIDTH    = 64,
  parameter int unsigned REQ_BYTE_EN_WIDTH = REQ_DATA_WIDTH / 8,
  parameter int unsigned REQ_ADDR_WIDTH    = 32,
  parameter int unsigned SEW_WIDTH         = 2,
  parameter int unsigned OPSEL_WIDTH       = 9,
  parameter int unsigned VL_WIDTH          = 11
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [OPSEL_WIDTH-1:0]       cmd_opSel,
  input  logic [SEW_WIDTH-1:0]         cmd_sew,
  input  logic [VL_WIDTH-1:0]          cmd_vl,
  input  logic [REQ_ADDR_WIDTH-1:0]    cmd_src0_addr,
  input  logic [REQ_ADDR_WIDTH-1:0]    cmd_src1_addr,
  input  logic [REQ_ADDR_WIDTH-1:0]    cmd_dst_addr,
  output logic                         rd_en,
  output logic [REQ_ADDR_WIDTH-1:0]    rd_addr0,
  output logic [REQ_ADDR_WIDTH-1:0]    rd_addr1,
  input  logic                         rd_gnt,
  input  logic [REQ_DATA_WIDTH-1:0]    rd_data0,
  input  logic [REQ_DATA_WIDTH-1:0]    rd_data1,
  output logic [REQ_DATA_WIDTH-1:0]    out_vec0,
  output logic [REQ_DATA_WIDTH-1:0]    out_vec1,
  output logic                         out_valid,
  output logic [SEW_WIDTH-1:0]         out_sew,
  output logic [OPSEL_WIDTH-1:0]       out_opSel,
  output logic [REQ_ADDR_WIDTH-1:0]    out_addr,
  output logic [2:0]                   out_start_idx,
  output logic                         out_req_start,
  output logic                         out_req_end,
  output logic [REQ_BYTE_EN_WIDTH-1:0] out_be
);

  localparam int unsigned BytesWidth = VL_WIDTH + 3;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;
  state_e state_q, state_d;

  logic [OPSEL_WIDTH-1:0]    opsel_q;
  logic [SEW_WIDTH-1:0]      sew_q;
  logic [REQ_ADDR_WIDTH-1:0] src0_q, src1_q, dst_q;
  logic [2:0]                rem_q;
  logic [VL_WIDTH-1:0]       last_k_q, k_q;

  logic                         p_valid_q, p_start_q, p_end_q;
  logic [REQ_ADDR_WIDTH-1:0]    p_addr_q;
  logic [2:0]                   p_idx_q;
  logic [REQ_BYTE_EN_WIDTH-1:0] p_be_q;

  logic [BytesWidth-1:0]        cmd_bytes;
  logic [VL_WIDTH-1:0]          cmd_chunks;
  logic                         k_last, rd_fire, mask_op;
  logic [REQ_ADDR_WIDTH-1:0]    k_ext, meta_addr;
  logic [2:0]                   meta_idx;
  logic [REQ_BYTE_EN_WIDTH-1:0] be_ones, meta_be;

  assign cmd_bytes  = {3'b000, cmd_vl} << cmd_sew;
  assign cmd_chunks = VL_WIDTH'((cmd_bytes + BytesWidth'(7)) >> 3);

  assign k_last  = (k_q == last_k_q);
  assign rd_fire = rd_en & rd_gnt;
  assign mask_op = opsel_q[OPSEL_WIDTH-1];
  assign k_ext   = REQ_ADDR_WIDTH'(k_q);
  assign be_ones = {REQ_BYTE_EN_WIDTH{1'b1}};

  // Mask ops pack eight chunks' results into one destination word.
  assign meta_addr = dst_q + (mask_op ? (k_ext >> 3) : k_ext);
  assign meta_idx  = mask_op ? k_q[2:0] : 3'b000;
  assign meta_be   = (k_last && rem_q != 3'b000) ? ~(be_ones << rem_q) : be_ones;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (cmd_valid && cmd_chunks != '0) state_d = StIssue;
      StIssue: if (rd_gnt && k_last) state_d = StWait;
      StWait:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    rd_en     = 1'b0;
    rd_addr0  = '0;
    rd_addr1  = '0;
    unique case (state_q)
      StIdle:  cmd_ready = 1'b1;
      StIssue: begin
        rd_en    = 1'b1;
        rd_addr0 = src0_q + k_ext;
        rd_addr1 = src1_q + k_ext;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opsel_q       <= '0;
      sew_q         <= '0;
      src0_q        <= '0;
      src1_q        <= '0;
      dst_q         <= '0;
      rem_q         <= '0;
      last_k_q      <= '0;
      k_q           <= '0;
      p_valid_q     <= 1'b0;
      p_start_q     <= 1'b0;
      p_end_q       <= 1'b0;
      p_addr_q      <= '0;
      p_idx_q       <= '0;
      p_be_q        <= '0;
      out_valid     <= 1'b0;
      out_vec0      <= '0;
      out_vec1      <= '0;
      out_sew       <= '0;
      out_opSel     <= '0;
      out_addr      <= '0;
      out_start_idx <= '0;
      out_req_start <= 1'b0;
      out_req_end   <= 1'b0;
      out_be        <= '0;
    end else begin
      if (state_q == StIdle && cmd_valid) begin
        opsel_q  <= cmd_opSel;
        sew_q    <= cmd_sew;
        src0_q   <= cmd_src0_addr;
        src1_q   <= cmd_src1_addr;
        dst_q    <= cmd_dst_addr;
        rem_q    <= cmd_bytes[2:0];
        last_k_q <= cmd_chunks - VL_WIDTH'(1);
        k_q      <= '0;
      end else if (rd_fire) begin
        k_q <= k_q + VL_WIDTH'(1);
      end

      // Metadata rides one stage so it lines up with the read data returning next cycle.
      p_valid_q <= rd_fire;
      if (rd_fire) begin
        p_start_q <= (k_q == '0);
        p_end_q   <= k_last;
        p_addr_q  <= meta_addr;
        p_idx_q   <= meta_idx;
        p_be_q    <= meta_be;
      end

      out_valid <= p_valid_q;
      if (p_valid_q) begin
        out_vec0      <= rd_data0;
        out_vec1      <= rd_data1;
        out_sew       <= sew_q;
        out_opSel     <= opsel_q;
        out_addr      <= p_addr_q;
        out_start_idx <= p_idx_q;
        out_req_start <= p_start_q;
        out_req_end   <= p_end_q;
        out_be        <= p_be_q;
      end else begin
        out_vec0      <= '0;
        out_vec1      <= '0;
        out_sew       <= '0;
        out_opSel     <= '0;
        out_addr      <= '0;
        out_start_idx <= '0;
        out_req_start <= 1'b0;
        out_req_end   <= 1'b0;
        out_be        <= '0;
      end
    end
  end

endmodule
